// File: rtl/im_boot_loader_pkg.sv
// ---------------------------------------------------------------------------
// im_boot_loader_pkg
// Shared constants and types for the instruction-memory boot loader.
// The IM geometry (ADDR_W/DEPTH) matches the 5-bit word address PC[6:2]
// used by the single-cycle MIPS core's IM and PC blocks.
// ---------------------------------------------------------------------------
package im_boot_loader_pkg;

  localparam int IM_ADDR_W  = 5;
  localparam int IM_DEPTH   = 32;
  localparam int BYTE_LANES = 4;
  localparam int LANE_W     = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LOAD,
    ST_DONE,
    ST_ERR
  } loader_state_e;

endpackage

// File: rtl/im_boot_loader_word_packer.sv
// ---------------------------------------------------------------------------
// im_boot_loader_word_packer
// Packs a byte stream big-endian into 32-bit words (1st byte -> [31:24]).
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   flush_i      drop any partial word and restart at lane 0
//   valid_i      a byte is being accepted this cycle
//   data_i       the byte
//   word_valid_o high in the cycle the 4th byte of a word is accepted
//   word_o       assembled word, valid together with word_valid_o
// ---------------------------------------------------------------------------
module im_boot_loader_word_packer
  import im_boot_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        valid_i,
  input  logic [7:0]  data_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [LANE_W-1:0] lane_q;
  logic [23:0]       shift_q;

  // The last lane is not stored: the word is completed combinationally with
  // the incoming byte so the top can register it in the same edge.
  assign word_valid_o = valid_i && (lane_q == LANE_W'(BYTE_LANES - 1));
  assign word_o       = {shift_q, data_i};

  // Flush wins over a byte so a new load always starts on lane 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lane_q  <= '0;
      shift_q <= '0;
    end else if (flush_i) begin
      lane_q  <= '0;
      shift_q <= '0;
    end else if (valid_i) begin
      lane_q  <= lane_q + 1'b1;
      shift_q <= {shift_q[15:0], data_i};
    end
  end

endmodule

// File: rtl/im_boot_loader.sv
// ---------------------------------------------------------------------------
// im_boot_loader
// Receives a UART byte stream (header byte N, then N*4 image bytes), writes
// the packed words into the instruction memory and holds the CPU in reset
// until the image is complete.
// Ports:
//   clk_i         clock, rising edge
//   rst_ni        asynchronous active-low reset
//   start_i       pulse: begin a new load (ignored while loading)
//   byte_valid_i  upstream byte present
//   byte_data_i   upstream byte
//   byte_ready_o  byte accepted when byte_valid_i & byte_ready_o
//   im_we_o       IM write enable, one cycle per word
//   im_addr_o     IM word address
//   im_wdata_o    IM write data
//   cpu_hold_o    holds the CPU/PC in reset while 1
//   done_o        image loaded (level until next start)
//   err_o         load failed (level until next start)
//   word_count_o  words written in the current/last load
// ---------------------------------------------------------------------------
module im_boot_loader
  import im_boot_loader_pkg::*;
#(
  parameter int ADDR_W  = IM_ADDR_W,
  parameter int DEPTH   = IM_DEPTH,
  parameter int TIMEOUT = 100000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic              im_we_o,
  output logic [ADDR_W-1:0] im_addr_o,
  output logic [31:0]       im_wdata_o,
  output logic              cpu_hold_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   word_count_o
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  loader_state_e     state_q, state_d;
  logic [CNT_W-1:0]  nWords_q, nWords_d;
  logic [CNT_W-1:0]  wordCount_q, wordCount_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              byteReady_q, byteReady_d;
  logic              imWe_q, imWe_d;
  logic [ADDR_W-1:0] imAddr_q, imAddr_d;
  logic [31:0]       imWdata_q, imWdata_d;
  logic              cpuHold_q, cpuHold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              accept;
  logic              flush;
  logic              packValid;
  logic              wordValid;
  logic [31:0]       word;
  logic              lastWord;
  logic              timerTerminal;

  assign accept        = byte_valid_i && byteReady_q;
  assign packValid     = accept && (state_q == ST_LOAD);
  assign lastWord      = wordValid && ((wordCount_q + CNT_W'(1)) == nWords_q);
  assign timerTerminal = (timer_q == TMR_W'(TIMEOUT - 1));

  im_boot_loader_word_packer u_packer (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush),
    .valid_i      (packValid),
    .data_i       (byte_data_i),
    .word_valid_o (wordValid),
    .word_o       (word)
  );

  // Next-state logic. All outputs are derived from state_d so they appear
  // registered alongside the state. After the final word's 4th byte the
  // FSM stays in LOAD for the write cycle with byte_ready already low, then
  // moves to DONE; no extra byte can sneak in.
  always_comb begin
    state_d     = state_q;
    nWords_d    = nWords_q;
    wordCount_d = wordCount_q;
    timer_d     = timer_q;
    imWe_d      = 1'b0;
    imAddr_d    = imAddr_q;
    imWdata_d   = imWdata_q;
    flush       = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_i) begin
          state_d     = ST_HDR;
          wordCount_d = '0;
          timer_d     = '0;
          flush       = 1'b1;
        end
      end
      ST_HDR: begin
        if (accept) begin
          timer_d = '0;
          if (32'(byte_data_i) > 32'(DEPTH)) begin
            state_d = ST_ERR;
          end else begin
            nWords_d = (byte_data_i == 8'd0) ? CNT_W'(DEPTH) : CNT_W'(byte_data_i);
            state_d  = ST_LOAD;
          end
        end else if (timerTerminal) begin
          state_d = ST_ERR;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_LOAD: begin
        if (imWe_q && (wordCount_q == nWords_q)) begin
          state_d = ST_DONE;
        end else if (accept) begin
          timer_d = '0;
        end else if (timerTerminal) begin
          state_d = ST_ERR;
        end else begin
          timer_d = timer_q + 1'b1;
        end
        if (wordValid) begin
          imWe_d      = 1'b1;
          imAddr_d    = wordCount_q[ADDR_W-1:0];
          imWdata_d   = word;
          wordCount_d = wordCount_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    byteReady_d = (state_d == ST_HDR) || ((state_d == ST_LOAD) && !lastWord);
    cpuHold_d   = (state_d != ST_DONE);
    done_d      = (state_d == ST_DONE);
    err_d       = (state_d == ST_ERR);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      nWords_q    <= '0;
      wordCount_q <= '0;
      timer_q     <= '0;
      byteReady_q <= 1'b0;
      imWe_q      <= 1'b0;
      imAddr_q    <= '0;
      imWdata_q   <= '0;
      cpuHold_q   <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      nWords_q    <= nWords_d;
      wordCount_q <= wordCount_d;
      timer_q     <= timer_d;
      byteReady_q <= byteReady_d;
      imWe_q      <= imWe_d;
      imAddr_q    <= imAddr_d;
      imWdata_q   <= imWdata_d;
      cpuHold_q   <= cpuHold_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign byte_ready_o = byteReady_q;
  assign im_we_o      = imWe_q;
  assign im_addr_o    = imAddr_q;
  assign im_wdata_o   = imWdata_q;
  assign cpu_hold_o   = cpuHold_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign word_count_o = wordCount_q;

endmodule

// File: tb/tb_im_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_im_boot_loader
// Self-checking bench for im_boot_loader. A reference model turns each
// image (header + bytes) into the list of expected IM writes; a monitor
// compares every im_we cycle against that list.
// ---------------------------------------------------------------------------
module tb_im_boot_loader;

  localparam int ADDR_W  = 5;
  localparam int DEPTH   = 32;
  localparam int TIMEOUT = 40;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              start_i;
  logic              byte_valid_i;
  logic [7:0]        byte_data_i;
  logic              byte_ready_o;
  logic              im_we_o;
  logic [ADDR_W-1:0] im_addr_o;
  logic [31:0]       im_wdata_o;
  logic              cpu_hold_o;
  logic              done_o;
  logic              err_o;
  logic [ADDR_W:0]   word_count_o;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  logic [31:0] expData[$];
  int          expAddr[$];
  logic [7:0]  img[$];
  bit          spacingOn = 1'b0;
  int          lastWeCycle = -1;

  im_boot_loader #(
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .byte_valid_i (byte_valid_i),
    .byte_data_i  (byte_data_i),
    .byte_ready_o (byte_ready_o),
    .im_we_o      (im_we_o),
    .im_addr_o    (im_addr_o),
    .im_wdata_o   (im_wdata_o),
    .cpu_hold_o   (cpu_hold_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .word_count_o (word_count_o)
  );

  // 10 ns clock and a free-running cycle counter used for write spacing.
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Every IM write must match the head of the expected-write list.
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && im_we_o === 1'b1) begin
      if (expData.size() == 0) begin
        checkOutput("unexpected_write", 64'(im_we_o), 64'd0);
      end else begin
        checkOutput("im_addr", 64'(im_addr_o), 64'(expAddr.pop_front()));
        checkOutput("im_wdata", 64'(im_wdata_o), 64'(expData.pop_front()));
      end
      if (spacingOn && lastWeCycle >= 0)
        checkOutput("we_spacing", 64'(cycle - lastWeCycle), 64'd4);
      lastWeCycle = cycle;
    end
  end

  // Reference model: word w of an image is bytes 4w..4w+3, big-endian, at address w.
  task automatic expectWords(input int nWords);
    for (int w = 0; w < nWords; w++) begin
      expData.push_back({img[4*w], img[4*w+1], img[4*w+2], img[4*w+3]});
      expAddr.push_back(w);
    end
  endtask

  task automatic applyReset();
    rst_ni       = 1'b0;
    start_i      = 1'b0;
    byte_valid_i = 1'b0;
    byte_data_i  = 8'h00;
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_byte_ready"}, 64'(byte_ready_o), 64'd0);
    checkOutput({tag, "_im_we"},      64'(im_we_o),      64'd0);
    checkOutput({tag, "_im_addr"},    64'(im_addr_o),    64'd0);
    checkOutput({tag, "_im_wdata"},   64'(im_wdata_o),   64'd0);
    checkOutput({tag, "_cpu_hold"},   64'(cpu_hold_o),   64'd1);
    checkOutput({tag, "_done"},       64'(done_o),       64'd0);
    checkOutput({tag, "_err"},        64'(err_o),        64'd0);
    checkOutput({tag, "_word_count"}, 64'(word_count_o), 64'd0);
  endtask

  task automatic pulseStart();
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
  endtask

  // Offer one byte after 'gap' idle cycles and hold it until accepted.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int waited = 0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk_i);
      #1;
    end
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    @(negedge clk_i);
    while (byte_ready_o !== 1'b1 && waited < 20) begin
      @(negedge clk_i);
      waited++;
    end
    if (byte_ready_o !== 1'b1) begin
      checkOutput("byte_ready_wait", 64'(byte_ready_o), 64'd1);
      byte_valid_i = 1'b0;
      return;
    end
    @(posedge clk_i);
    #1;
    byte_valid_i = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget);
    int n = 0;
    while (done_o !== 1'b1 && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput({tag, "_done"}, 64'(done_o), 64'd1);
  endtask

  task automatic checkLoaded(input string tag, input int nWords);
    checkOutput({tag, "_cpu_hold"},   64'(cpu_hold_o),   64'd0);
    checkOutput({tag, "_err"},        64'(err_o),        64'd0);
    checkOutput({tag, "_word_count"}, 64'(word_count_o), 64'(nWords));
    checkOutput({tag, "_byte_ready"}, 64'(byte_ready_o), 64'd0);
    checkOutput({tag, "_exp_left"},   64'(expData.size()), 64'd0);
  endtask

  // Random image of nWords words with header hdr and random inter-byte gaps.
  task automatic loadImage(input string tag, input int hdr, input int nWords, input int maxGap);
    img.delete();
    for (int i = 0; i < nWords * 4; i++) img.push_back(8'($urandom_range(0, 255)));
    expectWords(nWords);
    pulseStart();
    applyStimulus(8'(hdr), 0);
    for (int i = 0; i < nWords * 4; i++) applyStimulus(img[i], $urandom_range(0, maxGap));
    waitDone(tag, 20);
    checkLoaded(tag, nWords);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    applyReset();
    @(negedge clk_i);
    checkResetValues("reset");

    // Two-word image with fixed bytes.
    img.delete();
    img.push_back(8'h3C); img.push_back(8'h01); img.push_back(8'h10); img.push_back(8'h20);
    img.push_back(8'h08); img.push_back(8'h00); img.push_back(8'h00); img.push_back(8'h00);
    expData.push_back(32'h3C011020); expAddr.push_back(0);
    expData.push_back(32'h08000000); expAddr.push_back(1);
    pulseStart();
    applyStimulus(8'h02, 0);
    for (int i = 0; i < 8; i++) applyStimulus(img[i], 0);
    waitDone("basic", 20);
    checkLoaded("basic", 2);

    // Header 0 means a full 32-word image; a further byte is refused.
    loadImage("full", 0, DEPTH, 2);
    byte_valid_i = 1'b1;
    byte_data_i  = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checkOutput("full_refuse", 64'(byte_ready_o), 64'd0);
    end
    byte_valid_i = 1'b0;

    // Oversized header goes straight to ERR.
    pulseStart();
    applyStimulus(8'h21, 0);
    @(negedge clk_i);
    checkOutput("hdr_big_err",      64'(err_o),      64'd1);
    checkOutput("hdr_big_cpu_hold", 64'(cpu_hold_o), 64'd1);
    checkOutput("hdr_big_done",     64'(done_o),     64'd0);

    // Partial word then silence: timeout, nothing written, then recover.
    pulseStart();
    checkOutput("restart_err_clr", 64'(err_o), 64'd0);
    applyStimulus(8'h01, 0);
    for (int i = 0; i < 3; i++) applyStimulus(8'(8'h50 + i), 0);
    repeat (TIMEOUT - 2) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("tmo_early", 64'(err_o), 64'd0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("tmo_err",      64'(err_o),      64'd1);
    checkOutput("tmo_cpu_hold", 64'(cpu_hold_o), 64'd1);
    loadImage("after_tmo", 3, 3, 3);

    // Asynchronous reset in the middle of a two-word load.
    img.delete();
    for (int i = 0; i < 8; i++) img.push_back(8'($urandom_range(0, 255)));
    expectWords(1);
    pulseStart();
    applyStimulus(8'h02, 0);
    for (int i = 0; i < 5; i++) applyStimulus(img[i], 0);
    #3;
    rst_ni = 1'b0;
    #1;
    checkResetValues("async_rst");
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    loadImage("post_rst", 2, 2, 1);

    // Back-to-back bytes with an ignored start pulse in the middle.
    img.delete();
    for (int i = 0; i < 16; i++) img.push_back(8'($urandom_range(0, 255)));
    expectWords(4);
    pulseStart();
    applyStimulus(8'h04, 0);
    spacingOn   = 1'b1;
    lastWeCycle = -1;
    for (int i = 0; i < 16; i++) begin
      start_i = (i == 6);
      applyStimulus(img[i], 0);
    end
    start_i = 1'b0;
    waitDone("stream", 20);
    spacingOn = 1'b0;
    checkLoaded("stream", 4);

    // Randomised images.
    for (int it = 0; it < 5; it++) begin
      n = $urandom_range(1, DEPTH);
      loadImage("rand", (n == DEPTH) ? 0 : n, n, 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
